aes_ct_done_monitor: RTL and testbench
======================================

Name: aes_ct_done_monitor

Overview:
- Parametrised successor to the single-DUT AES timing harness's "first-stable" done detector.
- Sits between a crypto DUT output bus and the property/checker layer.
- Per run, measures the cycles until the DUT output settles for a programmable number of consecutive cycles.
- Reports that latency, the settled value, and a timeout, so constant-time checks compare latency_o across secret-differing runs.

Parameters:
- WIDTH, 128, width of the monitored DUT output bus.
- STABLE_CYCLES, 1, consecutive unchanged samples required to declare done (legal 1..15).
- TIMEOUT, 64, maximum RUN cycles before aborting (legal 1..2^CNT_W-1).
- CNT_W, 8, width of the cycle counter and latency_o.
- REQUIRE_CHANGE, 1, 1 means done only after at least one observed change; 0 means stability from the first sample counts.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  one-cycle start/restart request; samples data_i as reference.
- data_i  input  WIDTH  DUT output under observation.
- busy_o  output  1  high while in RUN.
- done_o  output  1  one-cycle pulse when stability is reached.
- timeout_o  output  1  one-cycle pulse when TIMEOUT expires.
- valid_o  output  1  level; result_o/latency_o hold a completed run (DONE or TIMEOUT).
- latency_o  output  CNT_W  RUN-cycle index of the qualifying sample, or TIMEOUT.
- result_o  output  WIDTH  data_i captured at the qualifying sample.
- sig_o  output  32  XOR-fold signature of result_o (see Optional Feature).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- On rst_n low:
  - State goes to IDLE.
  - All outputs, counters, ref_q, seen_change and stable_cnt clear to 0.
  - Outputs are low/0 in the first cycle after reset deasserts.
- FSM states: IDLE, RUN, DONE, TOUT.
- start_i is honoured in every state, including RUN (abort and restart) and same-cycle with a completion (start wins).
  - Next state is RUN; ref_q <= data_i; cyc_cnt <= 0; stable_cnt <= 0; seen_change <= 0; valid_o <= 0.
- RUN, each cycle k = 1, 2, ...:
  - cyc_cnt <= k.
  - changed = (data_i != ref_q); then ref_q <= data_i.
  - If changed: seen_change <= 1 and stable_cnt <= 0.
  - Else, if seen_change or REQUIRE_CHANGE==0: stable_cnt <= stable_cnt+1.
  - Qualifying sample: not changed, (seen_change or !REQUIRE_CHANGE), and stable_cnt+1 == STABLE_CYCLES.
  - On a qualifying sample: go to DONE; latency_o <= k; result_o <= data_i; valid_o <= 1; done_o high for exactly the next cycle.
  - Else if k == TIMEOUT: go to TOUT; latency_o <= TIMEOUT; result_o <= data_i; valid_o <= 1; timeout_o high for exactly the next cycle.
  - If qualifying and k == TIMEOUT in the same cycle, DONE wins.
- DONE/TOUT: hold latency_o, result_o and valid_o until start_i or reset. done_o and timeout_o are never high simultaneously.
- busy_o = (state == RUN), registered.
- Width rules:
  - stable_cnt is 4 bits and never exceeds STABLE_CYCLES.
  - cyc_cnt cannot wrap because TIMEOUT < 2^CNT_W.
  - The comparison is the full WIDTH-bit equality; no masking.
- Mid-run reset aborts immediately; no done_o or timeout_o is produced for the aborted run.

Optional Feature:
- Macro AES_CT_MON_SIG_EN.
- Defined: sig_o = XOR of the 32-bit slices of result_o. WIDTH is zero-padded to a multiple of 32, slice 0 = bits [31:0]. It updates in the same cycle as result_o.
- Undefined: sig_o is constant 0 and no fold logic is synthesised.

Test Plan:
- Defaults; start_i at cycle 0 with data_i=A. Cycles 1-2: A. Cycles 3-4: B -> done_o pulse in cycle 5; latency_o=4; result_o=B; valid_o=1; busy_o=0.
- STABLE_CYCLES=3; data_i: A (start), B at k=1, B for k=2..4 -> latency_o=4, done_o in cycle 5. Also: a glitch to C at k=3 delays done to latency_o=6.
- TIMEOUT=10, data_i toggling every cycle -> timeout_o pulse in cycle 11; latency_o=10; valid_o=1; done_o never asserts.
- REQUIRE_CHANGE=0, data_i constant A -> done_o after latency_o=STABLE_CYCLES (1), result_o=A. With REQUIRE_CHANGE=1, the same stimulus times out at TIMEOUT.
- start_i reasserted at k=2 of a run, then a rst_n pulse at k=3 of the new run -> counters restart at k=1 after each event. No done_o/timeout_o appears for the aborted runs, and all outputs are 0 after reset.
- AES_CT_MON_SIG_EN defined, WIDTH=64, result 0x00000001_00000003 -> sig_o=0x00000002. Undefined -> sig_o=0.

Source files
------------

// File: rtl/aes_ct_done_monitor.sv
// rtl/aes_ct_done_monitor.sv - per-run settle-latency monitor for a crypto DUT output bus (optional signature fold: AES_CT_MON_SIG_EN)
module aes_ct_done_monitor #(
    parameter int WIDTH          = 128,
    parameter int STABLE_CYCLES  = 1,
    parameter int TIMEOUT        = 64,
    parameter int CNT_W          = 8,
    parameter int REQUIRE_CHANGE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] latency_o,
    output logic [WIDTH-1:0] result_o,
    output logic [31:0]      sig_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_TOUT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [4:0]       STABLE_C  = 5'(STABLE_CYCLES);
    localparam logic             REQ_CHG_C = (REQUIRE_CHANGE != 0);

    state_t           state;
    logic [WIDTH-1:0] ref_q;
    logic [CNT_W-1:0] cyc_cnt;
    logic [3:0]       stable_cnt;
    logic             seen_change;

    logic [CNT_W-1:0] cyc_next;
    logic             changed;
    logic             count_ok;
    logic             qualify;
    logic             expired;

    // Per-sample decisions for the RUN state: k = cyc_cnt + 1 is the index of the sample on this edge
    always_comb begin
        cyc_next = cyc_cnt + 1'b1;
        changed  = (data_i != ref_q);
        count_ok = seen_change || !REQ_CHG_C;
        qualify  = !changed && count_ok && (({1'b0, stable_cnt} + 5'd1) == STABLE_C);
        expired  = (cyc_next == TIMEOUT_C);
    end

    // Run control FSM with registered status/result outputs; start_i overrides every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ref_q       <= '0;
            cyc_cnt     <= '0;
            stable_cnt  <= '0;
            seen_change <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            timeout_o   <= 1'b0;
            valid_o     <= 1'b0;
            latency_o   <= '0;
            result_o    <= '0;
        end else begin
            done_o    <= 1'b0;
            timeout_o <= 1'b0;
            if (start_i) begin
                state       <= S_RUN;
                ref_q       <= data_i;
                cyc_cnt     <= '0;
                stable_cnt  <= '0;
                seen_change <= 1'b0;
                valid_o     <= 1'b0;
                busy_o      <= 1'b1;
            end else begin
                case (state)
                    S_RUN: begin
                        cyc_cnt <= cyc_next;
                        ref_q   <= data_i;
                        if (changed) begin
                            seen_change <= 1'b1;
                            stable_cnt  <= '0;
                        end else if (count_ok) begin
                            stable_cnt <= stable_cnt + 1'b1;
                        end
                        if (qualify) begin
                            state     <= S_DONE;
                            latency_o <= cyc_next;
                            result_o  <= data_i;
                            valid_o   <= 1'b1;
                            done_o    <= 1'b1;
                            busy_o    <= 1'b0;
                        end else if (expired) begin
                            state     <= S_TOUT;
                            latency_o <= TIMEOUT_C;
                            result_o  <= data_i;
                            valid_o   <= 1'b1;
                            timeout_o <= 1'b1;
                            busy_o    <= 1'b0;
                        end
                    end
                    default: begin
                        // IDLE, DONE and TOUT hold their results until the next start
                        state <= state;
                    end
                endcase
            end
        end
    end

`ifdef AES_CT_MON_SIG_EN
    localparam int NSL = (WIDTH + 31) / 32;

    logic [NSL*32-1:0] result_pad;
    logic [31:0]       sig_fold;

    assign result_pad = (NSL*32)'(result_o);

    // XOR-fold of the zero-padded result, slice 0 = bits [31:0]
    always_comb begin
        sig_fold = '0;
        for (int i = 0; i < NSL; i++) begin
            sig_fold = sig_fold ^ result_pad[i*32 +: 32];
        end
    end

    assign sig_o = sig_fold;
`else
    assign sig_o = '0;
`endif

endmodule

// File: tb/tb_aes_ct_done_monitor.sv
// tb/tb_aes_ct_done_monitor.sv - randomized self-checking bench for aes_ct_done_monitor
module tb_aes_ct_done_monitor;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_i = 1'b0;
    logic [127:0] data_i = '0;

    always #5 clk = ~clk;

    // instance 0: defaults; 1: W64 S1 T10 RC1; 2: W64 S3 T20 RC1; 3: W64 S1 T10 RC0
    int P_S[4]  = '{1, 1, 3, 1};
    int P_T[4]  = '{64, 10, 20, 10};
    int P_RC[4] = '{1, 1, 1, 0};
    int P_W[4]  = '{128, 64, 64, 64};

    logic         b0, b1, b2, b3, d0, d1, d2, d3, t0, t1, t2, t3, v0, v1, v2, v3;
    logic [7:0]   l0, l1, l2, l3;
    logic [127:0] r0;
    logic [63:0]  r1, r2, r3;
    logic [31:0]  g0, g1, g2, g3;

    aes_ct_done_monitor u_m0 (.clk(clk), .rst_n(rst_n), .start_i(start_i), .data_i(data_i),
        .busy_o(b0), .done_o(d0), .timeout_o(t0), .valid_o(v0), .latency_o(l0), .result_o(r0), .sig_o(g0));
    aes_ct_done_monitor #(.WIDTH(64), .STABLE_CYCLES(1), .TIMEOUT(10), .CNT_W(8), .REQUIRE_CHANGE(1)) u_m1 (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .data_i(data_i[63:0]),
        .busy_o(b1), .done_o(d1), .timeout_o(t1), .valid_o(v1), .latency_o(l1), .result_o(r1), .sig_o(g1));
    aes_ct_done_monitor #(.WIDTH(64), .STABLE_CYCLES(3), .TIMEOUT(20), .CNT_W(8), .REQUIRE_CHANGE(1)) u_m2 (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .data_i(data_i[63:0]),
        .busy_o(b2), .done_o(d2), .timeout_o(t2), .valid_o(v2), .latency_o(l2), .result_o(r2), .sig_o(g2));
    aes_ct_done_monitor #(.WIDTH(64), .STABLE_CYCLES(1), .TIMEOUT(10), .CNT_W(8), .REQUIRE_CHANGE(0)) u_m3 (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .data_i(data_i[63:0]),
        .busy_o(b3), .done_o(d3), .timeout_o(t3), .valid_o(v3), .latency_o(l3), .result_o(r3), .sig_o(g3));

    logic         busy_w[4], done_w[4], tout_w[4], valid_w[4];
    logic [7:0]   lat_w[4];
    logic [127:0] res_w[4];
    logic [31:0]  sig_w[4];

    always_comb begin
        busy_w[0] = b0; busy_w[1] = b1; busy_w[2] = b2; busy_w[3] = b3;
        done_w[0] = d0; done_w[1] = d1; done_w[2] = d2; done_w[3] = d3;
        tout_w[0] = t0; tout_w[1] = t1; tout_w[2] = t2; tout_w[3] = t3;
        valid_w[0] = v0; valid_w[1] = v1; valid_w[2] = v2; valid_w[3] = v3;
        lat_w[0] = l0; lat_w[1] = l1; lat_w[2] = l2; lat_w[3] = l3;
        res_w[0] = r0; res_w[1] = {64'd0, r1}; res_w[2] = {64'd0, r2}; res_w[3] = {64'd0, r3};
        sig_w[0] = g0; sig_w[1] = g1; sig_w[2] = g2; sig_w[3] = g3;
    end

    int n_checks = 0;
    int n_pass = 0;

    // sample 0 is the reference taken with start_i; sample k is taken on RUN edge k
    logic [127:0] smp[$];

    int           ob_edge[4], ob_kind[4], ob_npulse[4], ob_both[4], ob_hold_bad[4];
    logic [7:0]   ob_lat[4];
    logic [127:0] ob_res[4];
    logic [31:0]  ob_sig[4];
    logic         ob_valid[4], ob_busy[4], ob_valid0[4], ob_busy0[4];

    function automatic logic [127:0] get_s(input int i);
        if (i < smp.size()) return smp[i];
        return smp[smp.size()-1];
    endfunction

    function automatic logic [31:0] fold(input logic [127:0] v);
        return v[31:0] ^ v[63:32] ^ v[95:64] ^ v[127:96];
    endfunction

    function automatic logic [31:0] exp_sig(input logic [127:0] v);
`ifdef AES_CT_MON_SIG_EN
        return fold(v);
`else
        return (v == v) ? 32'd0 : 32'd1;
`endif
    endfunction

    // Reference: done at the first k where samples k-S..k are all equal (k >= S) and, if a change is
    // required, some sample j <= k-S differed from its predecessor; otherwise timeout at T
    function automatic void model(input int i, output int kind, output int lat, output logic [127:0] res);
        logic [127:0] m;
        bit ok, chg;
        m = (P_W[i] == 128) ? {128{1'b1}} : {64'd0, {64{1'b1}}};
        for (int k = 1; k <= P_T[i]; k++) begin
            ok = (k >= P_S[i]);
            for (int j = k - P_S[i] + 1; ok && j <= k; j++)
                if ((get_s(j) & m) != (get_s(j-1) & m)) ok = 0;
            if (ok && P_RC[i] != 0) begin
                chg = 0;
                for (int j = 1; j <= k - P_S[i]; j++)
                    if ((get_s(j) & m) != (get_s(j-1) & m)) chg = 1;
                ok = chg;
            end
            if (ok) begin
                kind = 1; lat = k; res = get_s(k) & m;
                return;
            end
        end
        kind = 2; lat = P_T[i]; res = get_s(P_T[i]) & m;
    endfunction

    // Start a run with smp and watch every instance for ncyc RUN edges
    task automatic drive_run(input int ncyc);
        @(negedge clk); start_i = 1'b1; data_i = get_s(0);
        @(negedge clk); start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ob_valid0[i] = valid_w[i]; ob_busy0[i] = busy_w[i];
            ob_edge[i] = -1; ob_kind[i] = 0; ob_npulse[i] = 0; ob_both[i] = 0; ob_hold_bad[i] = 0;
        end
        for (int e = 1; e <= ncyc; e++) begin
            data_i = get_s(e);
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (done_w[i] && tout_w[i]) ob_both[i]++;
                if (done_w[i] || tout_w[i]) begin
                    ob_npulse[i]++;
                    if (ob_edge[i] < 0) begin
                        ob_edge[i] = e; ob_kind[i] = done_w[i] ? 1 : 2;
                        ob_lat[i] = lat_w[i]; ob_res[i] = res_w[i]; ob_sig[i] = sig_w[i];
                        ob_valid[i] = valid_w[i]; ob_busy[i] = busy_w[i];
                    end
                end else if (ob_edge[i] >= 0) begin
                    if (valid_w[i] !== 1'b1 || lat_w[i] !== ob_lat[i] || res_w[i] !== ob_res[i] || busy_w[i] !== 1'b0)
                        ob_hold_bad[i]++;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({busy_w[i], done_w[i], tout_w[i], valid_w[i], lat_w[i], res_w[i], sig_w[i]} !== '0)
                $display("FAIL reset_held inst%0d got busy=%b valid=%b lat=%0d res=%h want all 0", i, busy_w[i], valid_w[i], lat_w[i], res_w[i]);
            else n_pass++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({busy_w[i], done_w[i], tout_w[i], valid_w[i], lat_w[i], res_w[i], sig_w[i]} !== '0)
                $display("FAIL reset_release inst%0d got busy=%b valid=%b lat=%0d want all 0", i, busy_w[i], valid_w[i], lat_w[i]);
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        logic [127:0] a, b;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = ~a;
        smp = '{a, a, a, b, b};
        drive_run(8);
        n_checks++; if (ob_valid0[0] !== 1'b0 || ob_busy0[0] !== 1'b1) $display("FAIL basic_start got valid=%b busy=%b want 0 1", ob_valid0[0], ob_busy0[0]); else n_pass++;
        n_checks++; if (ob_edge[0] != 4 || ob_kind[0] != 1) $display("FAIL basic_done_cycle got edge=%0d kind=%0d want 4 1", ob_edge[0], ob_kind[0]); else n_pass++;
        n_checks++; if (ob_lat[0] !== 8'd4) $display("FAIL basic_latency got %0d want 4", ob_lat[0]); else n_pass++;
        n_checks++; if (ob_res[0] !== b) $display("FAIL basic_result got %h want %h", ob_res[0], b); else n_pass++;
        n_checks++; if (ob_valid[0] !== 1'b1 || ob_busy[0] !== 1'b0) $display("FAIL basic_flags got valid=%b busy=%b want 1 0", ob_valid[0], ob_busy[0]); else n_pass++;
        n_checks++; if (ob_npulse[0] != 1 || ob_hold_bad[0] != 0) $display("FAIL basic_pulse_hold got pulses=%0d holdbad=%0d want 1 0", ob_npulse[0], ob_hold_bad[0]); else n_pass++;
        // change only in bit 127 must be seen by the full-width compare
        b = a ^ {1'b1, 127'd0};
        smp = '{a, a, b, b};
        drive_run(6);
        n_checks++; if (ob_kind[0] != 1 || ob_lat[0] !== 8'd3) $display("FAIL msb_change got kind=%0d lat=%0d want 1 3", ob_kind[0], ob_lat[0]); else n_pass++;
    endtask

    task automatic test_stable3();
        logic [127:0] a, b, c;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = a ^ 128'h1; c = a ^ 128'h2;
        smp = '{a, b, b, b, b};
        drive_run(8);
        n_checks++; if (ob_kind[2] != 1 || ob_edge[2] != 4 || ob_lat[2] !== 8'd4) $display("FAIL s3_latency got kind=%0d edge=%0d lat=%0d want 1 4 4", ob_kind[2], ob_edge[2], ob_lat[2]); else n_pass++;
        n_checks++; if (ob_res[2] !== {64'd0, b[63:0]}) $display("FAIL s3_result got %h want %h", ob_res[2], b[63:0]); else n_pass++;
        smp = '{a, b, b, c, c, c, c};
        drive_run(9);
        n_checks++; if (ob_kind[2] != 1 || ob_edge[2] != 6 || ob_lat[2] !== 8'd6) $display("FAIL s3_glitch got kind=%0d edge=%0d lat=%0d want 1 6 6", ob_kind[2], ob_edge[2], ob_lat[2]); else n_pass++;
        n_checks++; if (ob_res[2] !== {64'd0, c[63:0]}) $display("FAIL s3_glitch_result got %h want %h", ob_res[2], c[63:0]); else n_pass++;
    endtask

    task automatic test_timeout();
        logic [127:0] a, b;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = ~a;
        smp = {};
        for (int k = 0; k < 70; k++) smp.push_back((k % 2 == 0) ? a : b);
        drive_run(68);
        n_checks++; if (ob_kind[1] != 2 || ob_edge[1] != 10 || ob_lat[1] !== 8'd10) $display("FAIL tout_t10 got kind=%0d edge=%0d lat=%0d want 2 10 10", ob_kind[1], ob_edge[1], ob_lat[1]); else n_pass++;
        n_checks++; if (ob_valid[1] !== 1'b1 || ob_npulse[1] != 1 || ob_both[1] != 0) $display("FAIL tout_t10_flags got valid=%b pulses=%0d both=%0d want 1 1 0", ob_valid[1], ob_npulse[1], ob_both[1]); else n_pass++;
        n_checks++; if (ob_res[1] !== {64'd0, a[63:0]}) $display("FAIL tout_t10_result got %h want %h", ob_res[1], a[63:0]); else n_pass++;
        n_checks++; if (ob_kind[0] != 2 || ob_edge[0] != 64 || ob_lat[0] !== 8'd64) $display("FAIL tout_t64 got kind=%0d edge=%0d lat=%0d want 2 64 64", ob_kind[0], ob_edge[0], ob_lat[0]); else n_pass++;
    endtask

    task automatic test_require_change();
        logic [127:0] a;
        a = {$urandom, $urandom, $urandom, $urandom};
        smp = '{a};
        drive_run(14);
        n_checks++; if (ob_kind[3] != 1 || ob_edge[3] != 1 || ob_lat[3] !== 8'd1) $display("FAIL rc0_done got kind=%0d edge=%0d lat=%0d want 1 1 1", ob_kind[3], ob_edge[3], ob_lat[3]); else n_pass++;
        n_checks++; if (ob_res[3] !== {64'd0, a[63:0]}) $display("FAIL rc0_result got %h want %h", ob_res[3], a[63:0]); else n_pass++;
        n_checks++; if (ob_kind[1] != 2 || ob_lat[1] !== 8'd10) $display("FAIL rc1_const got kind=%0d lat=%0d want 2 10", ob_kind[1], ob_lat[1]); else n_pass++;
    endtask

    task automatic test_restart();
        logic [127:0] a, b, c, d;
        int npl;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = a ^ 128'h1; c = a ^ 128'h2; d = a ^ 128'h3;
        npl = 0;
        @(negedge clk); start_i = 1'b1; data_i = a;
        @(negedge clk); start_i = 1'b0; data_i = b;
        @(negedge clk); npl += int'(d0 | t0 | d1 | t1);
        start_i = 1'b1; data_i = b;   // k=2 would qualify; the restart must win
        @(negedge clk); npl += int'(d0 | t0 | d1 | t1);
        n_checks++; if (b0 !== 1'b1 || v0 !== 1'b0) $display("FAIL restart_state got busy=%b valid=%b want 1 0", b0, v0); else n_pass++;
        start_i = 1'b0; data_i = c;
        @(negedge clk); npl += int'(d0 | t0 | d1 | t1);
        data_i = d;
        @(negedge clk); npl += int'(d0 | t0 | d1 | t1);
        rst_n = 1'b0;
        #1;
        n_checks++; if ({b0, d0, t0, v0, l0, r0, g0} !== '0) $display("FAIL async_reset got busy=%b valid=%b lat=%0d want all 0", b0, v0, l0); else n_pass++;
        n_checks++; if (npl != 0) $display("FAIL aborted_pulses got %0d want 0", npl); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if ({b0, d0, t0, v0, l0, r0, g0, b1, v1, l1} !== '0) $display("FAIL post_reset got busy=%b valid=%b lat=%0d want all 0", b0, v0, l0); else n_pass++;
        smp = '{a, b, b};
        drive_run(4);
        n_checks++; if (ob_kind[0] != 1 || ob_lat[0] !== 8'd2 || ob_edge[0] != 2) $display("FAIL restart_count got kind=%0d lat=%0d edge=%0d want 1 2 2", ob_kind[0], ob_lat[0], ob_edge[0]); else n_pass++;
    endtask

    task automatic test_sig();
        logic [127:0] x;
        int kind, lat;
        logic [127:0] mres;
        x = {64'd0, 64'h00000001_00000003};
        smp = '{128'd0, x, x};
        drive_run(4);
        n_checks++; if (ob_kind[1] != 1 || ob_res[1] !== x) $display("FAIL sig_run got kind=%0d res=%h want 1 %h", ob_kind[1], ob_res[1], x); else n_pass++;
`ifdef AES_CT_MON_SIG_EN
        n_checks++; if (ob_sig[1] !== 32'h2) $display("FAIL sig_w64 got %h want 00000002", ob_sig[1]); else n_pass++;
`else
        n_checks++; if (ob_sig[1] !== 32'h0) $display("FAIL sig_w64 got %h want 00000000", ob_sig[1]); else n_pass++;
`endif
        smp = '{128'd0, {$urandom, $urandom, $urandom, $urandom}};
        drive_run(4);
        model(0, kind, lat, mres);
        n_checks++; if (ob_sig[0] !== exp_sig(mres)) $display("FAIL sig_w128 got %h want %h", ob_sig[0], exp_sig(mres)); else n_pass++;
    endtask

    task automatic test_random();
        logic [127:0] pool[4];
        logic [127:0] cur, mres;
        int kind, lat;
        for (int r = 0; r < 30; r++) begin
            pool[0] = {$urandom, $urandom, $urandom, $urandom};
            pool[1] = pool[0] ^ {$urandom, $urandom, $urandom, 32'h1};
            pool[2] = pool[0] ^ {$urandom, $urandom, $urandom, 32'h2};
            pool[3] = pool[0] ^ {32'h8000_0000, 96'd0};
            cur = pool[$urandom_range(0, 3)];
            smp = {};
            for (int k = 0; k < 70; k++) begin
                if ($urandom_range(0, 3) == 0) cur = pool[$urandom_range(0, 3)];
                smp.push_back(cur);
            end
            drive_run(66);
            for (int i = 0; i < 4; i++) begin
                model(i, kind, lat, mres);
                n_checks++;
                if (ob_kind[i] != kind || ob_edge[i] != lat || ob_lat[i] !== 8'(lat) || ob_res[i] !== mres)
                    $display("FAIL rand%0d_inst%0d got kind=%0d edge=%0d lat=%0d res=%h want %0d %0d %0d %h", r, i, ob_kind[i], ob_edge[i], ob_lat[i], ob_res[i], kind, lat, lat, mres);
                else n_pass++;
                n_checks++;
                if (ob_npulse[i] != 1 || ob_both[i] != 0 || ob_hold_bad[i] != 0 || ob_valid[i] !== 1'b1 || ob_busy[i] !== 1'b0)
                    $display("FAIL rand%0d_inst%0d_flags got pulses=%0d both=%0d holdbad=%0d valid=%b busy=%b want 1 0 0 1 0", r, i, ob_npulse[i], ob_both[i], ob_hold_bad[i], ob_valid[i], ob_busy[i]);
                else n_pass++;
                n_checks++;
                if (ob_valid0[i] !== 1'b0 || ob_busy0[i] !== 1'b1 || ob_sig[i] !== exp_sig(mres))
                    $display("FAIL rand%0d_inst%0d_b2b got valid0=%b busy0=%b sig=%h want 0 1 %h", r, i, ob_valid0[i], ob_busy0[i], ob_sig[i], exp_sig(mres));
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stable3();
        test_timeout();
        test_require_change();
        test_restart();
        test_sig();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
